gbuf_port_arb: RTL

GBUF_PORT_ARB -- requirements
Module: gbuf_port_arb

---
 rtl/gbuf_port_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gbuf_port_arb.sv
// Two-requester arbiter in front of port A of the global buffer SRAM, with lock support.
// Define GBUF_ARB_RR_EN for round-robin contention handling; otherwise requester 0 wins.
module gbuf_port_arb #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req0_lock,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic              req1_lock,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              sram_a_we,
   output logic [ADDR_W-1:0] sram_a_addr,
   output logic [DATA_W-1:0] sram_a_wdata,
   input  logic [DATA_W-1:0] sram_a_rdata,
   output logic [15:0]       conflict_cnt
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t      state_q, state_d;
   logic        rd0_q, rd0_d;
   logic        rd1_q, rd1_d;
   logic [15:0] conflict_cnt_q, conflict_cnt_d;
   logic        acc0, acc1, stall;
`ifdef GBUF_ARB_RR_EN
   logic        last_q, last_d;
`endif

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst_i) begin
         unique case (state_q)
            IDLE: begin
               if (req0_valid && req1_valid) begin
`ifdef GBUF_ARB_RR_EN
                  req0_ready = last_q;
                  req1_ready = !last_q;
`else
                  req0_ready = 1'b1;
`endif
               end else begin
                  req0_ready = req0_valid;
                  req1_ready = req1_valid;
               end
            end
            LOCK0:   req0_ready = req0_valid;
            LOCK1:   req1_ready = req1_valid;
            default: ;
         endcase
      end
   end

   assign acc0  = req0_valid && req0_ready;
   assign acc1  = req1_valid && req1_ready;
   assign stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

   always_comb begin
      sram_a_we      = 1'b0;
      sram_a_addr    = '0;
      sram_a_wdata   = '0;
      state_d        = state_q;
      rd0_d          = acc0 && !req0_we;
      rd1_d          = acc1 && !req1_we;
      conflict_cnt_d = conflict_cnt_q;
`ifdef GBUF_ARB_RR_EN
      last_d         = last_q;
`endif
      if (acc0) begin
         sram_a_we    = req0_we;
         sram_a_addr  = req0_addr;
         sram_a_wdata = req0_wdata;
         state_d      = req0_lock ? LOCK0 : IDLE;
`ifdef GBUF_ARB_RR_EN
         last_d       = 1'b0;
`endif
      end else if (acc1) begin
         sram_a_we    = req1_we;
         sram_a_addr  = req1_addr;
         sram_a_wdata = req1_wdata;
         state_d      = req1_lock ? LOCK1 : IDLE;
`ifdef GBUF_ARB_RR_EN
         last_d       = 1'b1;
`endif
      end
      if (stall && conflict_cnt_q != 16'hFFFF) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         rd0_q          <= 1'b0;
         rd1_q          <= 1'b0;
         conflict_cnt_q <= '0;
`ifdef GBUF_ARB_RR_EN
         last_q         <= 1'b1;
`endif
      end else begin
         state_q        <= state_d;
         rd0_q          <= rd0_d;
         rd1_q          <= rd1_d;
         conflict_cnt_q <= conflict_cnt_d;
`ifdef GBUF_ARB_RR_EN
         last_q         <= last_d;
`endif
      end
   end

   // A reset arriving while a read is in flight swallows its response.
   assign rsp0_valid   = rd0_q && !rst_i;
   assign rsp1_valid   = rd1_q && !rst_i;
   assign rsp0_rdata   = rsp0_valid ? sram_a_rdata : '0;
   assign rsp1_rdata   = rsp1_valid ? sram_a_rdata : '0;
   assign conflict_cnt = conflict_cnt_q;

endmodule
